// File: rtl/packet_framer.sv
// packet_framer: wraps TLP/DLLP payload bytes in STP/SDP ... END/EDB K-symbols, PAD when idle.
// Define PACKET_FRAMER_STATS_EN to add the tlp_cnt/dllp_cnt/edb_cnt statistics outputs.
module packet_framer #(
  parameter int IDLE_PAD    = 1,
  parameter int MAX_TLP_LEN = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [1:0] in_type,
  input  logic       in_last,
  input  logic       in_abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_dk
`ifdef PACKET_FRAMER_STATS_EN
  ,
  output logic [15:0] tlp_cnt,
  output logic [15:0] dllp_cnt,
  output logic [15:0] edb_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DATA, EOF, DROP} state_t;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END_K = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] IDLE_DATA = (IDLE_PAD != 0) ? 8'hF7 : 8'h00;
  localparam logic IDLE_K = (IDLE_PAD != 0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TLP_LEN);
  state_t state, state_n;
  logic is_tlp, is_tlp_n, abort_q, abort_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] data_n;
  logic dk_n, valid_n;
  logic advance, accept, bad_type, ovf;
  assign advance = out_ready | ~out_valid;
  assign accept = in_valid & in_ready;
  assign bad_type = (in_type == 2'b00) || (in_type == 2'b11);
  assign ovf = is_tlp && (cnt == MAX_CNT);
  always_comb begin
    state_n = state;
    is_tlp_n = is_tlp;
    abort_n = abort_q;
    cnt_n = cnt;
    data_n = IDLE_DATA;
    dk_n = IDLE_K;
    valid_n = IDLE_K;
    in_ready = 1'b0;
    case (state)
      IDLE: if (advance && in_valid) begin
        if (bad_type) begin
          in_ready = 1'b1;
          state_n = in_last ? IDLE : DROP;
        end else begin
          data_n = (in_type == 2'b01) ? STP : SDP;
          dk_n = 1'b1;
          valid_n = 1'b1;
          is_tlp_n = (in_type == 2'b01);
          abort_n = 1'b0;
          cnt_n = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        in_ready = advance;
        if (accept && ovf) begin
          data_n = EDB;
          dk_n = 1'b1;
          valid_n = 1'b1;
          cnt_n = '0;
          state_n = in_last ? IDLE : DROP;
        end else if (accept) begin
          data_n = in_data;
          dk_n = 1'b0;
          valid_n = 1'b1;
          cnt_n = cnt + CNT_W'(1);
          abort_n = in_last ? (is_tlp & in_abort) : abort_q;
          state_n = in_last ? EOF : DATA;
        end else begin
          valid_n = 1'b0;
        end
      end
      EOF: begin
        data_n = abort_q ? EDB : END_K;
        dk_n = 1'b1;
        valid_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end
      default: begin
        in_ready = 1'b1;
        state_n = (accept && in_last) ? IDLE : DROP;
      end
    endcase
  end
  // DROP only swallows input, so it may leave without waiting for the output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      is_tlp <= 1'b0;
      abort_q <= 1'b0;
      cnt <= '0;
      out_valid <= IDLE_K;
      out_data <= IDLE_DATA;
      out_dk <= IDLE_K;
    end else if (advance) begin
      state <= state_n;
      is_tlp <= is_tlp_n;
      abort_q <= abort_n;
      cnt <= cnt_n;
      out_valid <= valid_n;
      out_data <= data_n;
      out_dk <= dk_n;
    end else if (state == DROP) begin
      state <= state_n;
    end
  end
`ifdef PACKET_FRAMER_STATS_EN
  logic end_ld, edb_ld;
  assign end_ld = advance && (state == EOF) && !abort_q;
  assign edb_ld = advance && (((state == EOF) && abort_q) || ((state == DATA) && accept && ovf));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt <= '0;
      dllp_cnt <= '0;
      edb_cnt <= '0;
    end else begin
      if (end_ld && is_tlp) tlp_cnt <= tlp_cnt + 16'd1;
      if (end_ld && !is_tlp) dllp_cnt <= dllp_cnt + 16'd1;
      if (edb_ld) edb_cnt <= edb_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: table of packets driven through the framer, output symbols checked against a queue.
module tb_packet_framer;
  localparam logic [8:0] PAD_S = {8'hF7, 1'b1};
  typedef struct {
    logic [1:0] typ;
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    logic       abort;
    int         fwd;
    logic [7:0] term;
    logic       gap;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, in_abort = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_type = 2'b00;
  logic in_ready, out_valid, out_dk;
  logic [7:0] out_data;
`ifdef PACKET_FRAMER_STATS_EN
  logic [15:0] tlp_cnt, dllp_cnt, edb_cnt;
  int exp_tlp = 0, exp_dllp = 0, exp_edb = 0;
`endif
  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] sym, e;
  logic mon_en = 1'b1, in_prog = 1'b0, after_term = 0;
  vec_t tbl[11];

  packet_framer #(.IDLE_PAD(1), .MAX_TLP_LEN(4), .CNT_W(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type),
    .in_last(in_last), .in_abort(in_abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_dk(out_dk)
`ifdef PACKET_FRAMER_STATS_EN
    , .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt), .edb_cnt(edb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] typ, input logic [7:0] base, input logic [7:0] step,
                          input int fwd, input logic [7:0] term);
    if (typ == 2'b01 || typ == 2'b10) begin
      exp_q.push_back({(typ == 2'b01) ? 8'hFB : 8'h5C, 1'b1});
      for (int i = 0; i < fwd; i++) exp_q.push_back({8'(base + i * step), 1'b0});
      exp_q.push_back({term, 1'b1});
`ifdef PACKET_FRAMER_STATS_EN
      if (term == 8'hFE) exp_edb++;
      else if (typ == 2'b01) exp_tlp++;
      else exp_dllp++;
`endif
    end
  endtask

  // Called just after a rising edge; in_ready is judged 1ns before the next one.
  task automatic send_pkt(input logic [1:0] typ, input int len, input logic [7:0] base,
                          input logic [7:0] step, input logic abort);
    for (int i = 0; i < len; i++) begin
      int t = 0;
      #1;
      in_valid = 1'b1;
      in_type = typ;
      in_data = 8'(base + i * step);
      in_last = (i == len - 1);
      in_abort = abort && (i == len - 1);
      do begin
        @(negedge clk);
        #4;
        t++;
      end while (!in_ready && t < 50);
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout byte %0d got in_ready 0 expected 1", i);
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_abort = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic stall_seq();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(out_valid && !out_dk && out_data == 8'h22) && t < 50);
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL stall_seen got none expected 22/0");
    end
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", 32'(out_data), 32'h22);
      chk("stall_dk", 32'(out_dk), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    #1 out_ready = 1'b1;
  endtask

  // Symbols are consumed when out_valid & out_ready; PAD only legal outside a packet.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      sym = {out_data, out_dk};
      if (exp_q.size() == 0) begin
        after_term = 1'b0;
        if (sym != PAD_S) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol got %h/%b expected F7/1", out_data, out_dk);
        end
      end else if (sym == PAD_S) begin
        if (in_prog || after_term) begin
          checks++;
          errors++;
          $display("FAIL pad_in_stream got F7/1 expected %h/%b", exp_q[0][8:1], exp_q[0][0]);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (sym !== e) begin
          errors++;
          $display("FAIL symbol got %h/%b expected %h/%b", out_data, out_dk, e[8:1], e[0]);
        end
        in_prog = !(e[0] && (e[8:1] == 8'hFD || e[8:1] == 8'hFE));
        after_term = !in_prog;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{2'b01, 3, 8'h11, 8'h11, 1'b0, 3, 8'hFD, 1'b1};
    tbl[1]  = '{2'b10, 6, 8'h00, 8'h01, 1'b0, 6, 8'hFD, 1'b0};
    tbl[2]  = '{2'b01, 1, 8'hA0, 8'h00, 1'b0, 1, 8'hFD, 1'b1};
    tbl[3]  = '{2'b01, 2, 8'hAA, 8'h11, 1'b1, 2, 8'hFE, 1'b1};
    tbl[4]  = '{2'b01, 6, 8'h01, 8'h01, 1'b0, 4, 8'hFE, 1'b1};
    tbl[5]  = '{2'b10, 2, 8'h10, 8'h01, 1'b1, 2, 8'hFD, 1'b1};
    tbl[6]  = '{2'b01, 4, 8'h41, 8'h01, 1'b0, 4, 8'hFD, 1'b1};
    tbl[7]  = '{2'b11, 3, 8'h70, 8'h01, 1'b0, 0, 8'h00, 1'b1};
    tbl[8]  = '{2'b00, 1, 8'h80, 8'h01, 1'b0, 0, 8'h00, 1'b1};
    tbl[9]  = '{2'b01, 5, 8'h31, 8'h01, 1'b0, 4, 8'hFE, 1'b0};
    tbl[10] = '{2'b01, 2, 8'h51, 8'h01, 1'b0, 2, 8'hFD, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 1);
    chk("rst_data", 32'(out_data), 32'hF7);
    chk("rst_dk", 32'(out_dk), 1);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 1);
      chk("idle_data", 32'(out_data), 32'hF7);
      chk("idle_dk", 32'(out_dk), 1);
      chk("idle_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    for (int k = 0; k < 11; k++) begin
      push_exp(tbl[k].typ, tbl[k].base, tbl[k].step, tbl[k].fwd, tbl[k].term);
      send_pkt(tbl[k].typ, tbl[k].len, tbl[k].base, tbl[k].step, tbl[k].abort);
      if (tbl[k].gap) wait_drain();
    end
    push_exp(2'b01, 8'h11, 8'h11, 3, 8'hFD);
    fork
      send_pkt(2'b01, 3, 8'h11, 8'h11, 1'b0);
      stall_seq();
    join
    wait_drain();
`ifdef PACKET_FRAMER_STATS_EN
    chk("tlp_cnt", 32'(tlp_cnt), 32'(exp_tlp));
    chk("dllp_cnt", 32'(dllp_cnt), 32'(exp_dllp));
    chk("edb_cnt", 32'(edb_cnt), 32'(exp_edb));
`endif
    mon_en = 1'b0;
    #1;
    in_valid = 1'b1;
    in_type = 2'b01;
    in_data = 8'h55;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 1);
    chk("midrst_data", 32'(out_data), 32'hF7);
    chk("midrst_dk", 32'(out_dk), 1);
    chk("midrst_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_data", 32'(out_data), 32'hF7);
    in_prog = 1'b0;
    after_term = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    push_exp(2'b01, 8'h66, 8'h01, 2, 8'hFD);
    send_pkt(2'b01, 2, 8'h66, 8'h01, 1'b0);
    wait_drain();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
Transmit-side framer for the 8-bit lane byte stream.
- Accepts TLP/DLLP payload bytes over a valid/ready interface.
- Emits framed symbols with a D/K flag:
  - STP or SDP, then payload, then END or EDB.
  - PAD when idle.
- Sits between the transmit packet source and the lane serializer/encoder. It is the sending counterpart of the receive-side packet identifier.

Parameters:
IDLE_PAD, 1, 1 = emit PAD K-symbols with out_valid=1 when idle; 0 = out_valid=0 and out_data=0 when idle
MAX_TLP_LEN, 4096, maximum TLP payload bytes forwarded before forced EDB termination (DLLPs not length-checked)
CNT_W, 13, width of internal byte counter; must hold MAX_TLP_LEN

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  payload byte available
in_ready  out  1  byte accepted when in_valid & in_ready
in_data  in  8  payload byte
in_type  in  2  01=TLP, 10=DLLP; sampled on first byte of packet only
in_last  in  1  final payload byte of packet
in_abort  in  1  sampled with in_last; TLP only, request nullify (EDB)
out_ready  in  1  downstream accepts current output symbol
out_valid  out  1  output symbol valid
out_data  out  8  symbol (STP 8'hFB, SDP 8'h5C, END 8'hFD, EDB 8'hFE, PAD 8'hF7)
out_dk  out  1  1 = K symbol, 0 = data byte

Behaviour:
- Outputs are registered.
- advance = out_ready | ~out_valid. The output register and the FSM update only on advance; otherwise all outputs hold.
- Reset (async, any state):
  - state=IDLE, counter=0.
  - out_data = IDLE_PAD ? 8'hF7 : 0; out_dk = IDLE_PAD; out_valid = IDLE_PAD.
  - Reset mid-packet drops the packet silently; no END is emitted.
- States: IDLE, DATA, EOF, DROP. A packet type register holds TLP/DLLP.
- IDLE:
  - in_ready=0.
  - If advance & in_valid & in_type==01: load STP (dk=1), type=TLP, go DATA.
  - If advance & in_valid & in_type==10: load SDP (dk=1), type=DLLP, go DATA.
  - If advance & in_valid & in_type is 00 or 11: in_ready=1 for that cycle, byte discarded, load idle symbol, go DROP unless in_last (stay IDLE).
  - Otherwise load idle symbol.
- DATA:
  - in_ready = advance.
  - On accept: load in_data with dk=0, counter+1.
  - If in_last, latch abort (only when type=TLP) and go EOF.
  - No input while advancing: load idle symbol with out_valid=0 (gap). PAD is not used inside a packet.
- TLP overflow (TLP, accept while counter==MAX_TLP_LEN):
  - Byte is not forwarded; load EDB (dk=1).
  - Go IDLE if in_last, else DROP.
- EOF:
  - On advance: load EDB if latched abort, else END (dk=1); counter=0; go IDLE.
  - in_ready=0.
- DROP:
  - in_ready=1; bytes discarded; load idle symbol.
  - On in_last accept: go IDLE.
- Latency:
  - Request in IDLE at cycle N → STP/SDP visible N+1.
  - First payload byte accepted N+1, visible N+2.
  - Byte with in_last accepted at M → END at M+2.
- Back-to-back packets: STP follows END directly with no PAD between them.
- in_type and in_abort are ignored on non-first / non-last beats respectively.

Optional Feature:
Macro: PACKET_FRAMER_STATS_EN
- Defined:
  - Adds outputs tlp_cnt[15:0], dllp_cnt[15:0], edb_cnt[15:0]; all reset to 0 and wrap on overflow.
  - tlp_cnt and dllp_cnt increment when END is loaded for that type.
  - edb_cnt increments on every EDB loaded (abort or overflow).
- Undefined: ports and counters absent; framing behaviour identical.

Test Plan:
- Reset with IDLE_PAD=1, out_ready=1 → out_valid=1, out_data=F7, out_dk=1 continuously; in_ready=0.
- TLP bytes 11,22,33 (last on 33), in_type=01, out_ready=1 → FB/1, 11/0, 22/0, 33/0, FD/1, then F7/1.
- DLLP 6 bytes 00..05 immediately followed by a TLP A0 (last) → 5C, 00..05, FD, FB, A0, FD; no PAD between FD and FB.
- TLP AA,BB with in_abort=1 on BB → FB, AA, BB, FE/1. With the stats macro: edb_cnt=1, tlp_cnt=0.
- MAX_TLP_LEN=4, 6-byte TLP 01..06 → FB, 01..04, FE. Bytes 05,06 consumed with in_ready=1 and not emitted, then F7.
- out_ready held 0 for 3 cycles mid-packet after byte 22 is shown → 22/0 held, in_ready=0 for those cycles; 33 follows once out_ready=1. Assert rst_n low mid-packet → F7/1 next cycle, in_ready=0.
